vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   Timing generator for a 640x480@60 Hz VGA output.
//   Divides the system clock (100 MHz) by 4 to produce a 25 MHz pixel-enable pulse p_tick.
//   Runs the horizontal and vertical scan counters and produces hsync, vsync, video_on and the pixel coordinates.
//   Sits between the clock domain root and the pixel/graphics generator (pong renderer).
// PARAMETERS
//   CLK_DIV    4    system clocks per pixel; p_tick period
//   H_DISP     640  visible pixels per line
//   H_FP       16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BP       48   horizontal back porch; line total = 800
//   V_DISP     480  visible lines per frame
//   V_FP       10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BP       33   vertical back porch; frame total = 525
//   SYNC_POL   0    sync pulse polarity; 0 = active-low
// PORTS
//   clk       in   1   system clock, 100 MHz; all logic on rising edge
//   reset     in   1   synchronous, active-high reset
//   hsync     out  1   horizontal sync, registered
//   vsync     out  1   vertical sync, registered
//   video_on  out  1   1 when (pixel_x,pixel_y) lies in the 640x480 visible area
//   p_tick    out  1   1-clk pulse every CLK_DIV clks (pixel enable)
//   pixel_x   out  10  current horizontal count, 0..799
//   pixel_y   out  10  current vertical count, 0..524
// BEHAVIOUR
//   Reset (sampled on a clk edge while reset=1):
//   - div_cnt=0, h_cnt=0, v_cnt=0.
//   - hsync=vsync=inactive (1 when SYNC_POL=0).
//   - p_tick=0, video_on=1, pixel_x=pixel_y=0.
//   Reset asserted mid-frame returns everything to these values on the next edge; no partial state survives.
//   Divider:
//   - 2-bit div_cnt increments every clk and wraps 3->0.
//   - p_tick = (div_cnt==CLK_DIV-1), combinational from the register; a glitch-free 1-cycle pulse.
//   - First p_tick is the 4th clk cycle after reset release; then every 4th cycle.
//   Horizontal counter:
//   - h_cnt advances only on clk edges where p_tick=1.
//   - 799 wraps to 0; that same edge is the end-of-line event.
//   Vertical counter:
//   - v_cnt advances only on the end-of-line edge (p_tick=1 and h_cnt=799).
//   - 524 wraps to 0 (end of frame); h and v wrap on the same edge at 799/524.
//   Sync outputs:
//   - hsync active when h_next in [656,751]; vsync active when v_next in [490,491].
//   - h_next/v_next are the next counter values, registered with the counters, so sync aligns exactly with the pixel_x/pixel_y values.
//   video_on = (h_cnt<640) && (v_cnt<480), combinational.
//   pixel_x = h_cnt and pixel_y = v_cnt, directly from the registers.
//   Width rules:
//   - Counters are 10 bits; all compare constants are derived from the parameters.
//   - The parameters must keep the totals <=1023.
//   Outputs change only on clk edges where p_tick=1 (except p_tick itself).
// STRUCTURE
//   vga_timing_pkg: H_/V_ timing localparams, derived totals and sync start/end bounds.
//   One sub-module mod_counter #(N,W) (clk, reset, en, q, wrap), instantiated three times:
//   - divider: N=4, en=1
//   - horizontal: N=800, en=p_tick
//   - vertical: N=525, en=p_tick&h_wrap
// TESTING
//   1. Reset 1 cycle then release -> p_tick=0 for 3 clks, 1 on the 4th clk, then period 40 ns.
//      pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1 during this time.
//   2. Run 640 p_ticks -> pixel_x=640, video_on=0.
//      hsync falls when pixel_x=656 and rises when pixel_x=752.
//   3. Run 800 p_ticks -> pixel_x wraps 799->0 and pixel_y becomes 1 on the same edge.
//   4. Run to pixel_y=490 -> vsync low for exactly 2 lines (490,491).
//      Frame wraps 524->0 after 420000 p_ticks (16.8 ms).
//   5. Assert reset mid-line (e.g. pixel_x=300, pixel_y=200) -> next edge gives all counters 0, syncs inactive, p_tick=0.
//   6. Hold reset high for 10 clks -> outputs stay at reset values, with no p_tick pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and small helpers shared by the VGA
// sync generator and its counter building block.
package vga_timing_pkg;

  localparam int CNT_W        = 10;
  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_DISP   = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_DISP   = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  // Maps "pulse active" onto the physical pin level for the chosen polarity.
  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; wrap flags the enabled edge on which N-1 rolls to 0.
module mod_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] r_q;

  assign wrap = en && (r_q == W'(N - 1));
  assign q    = r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= wrap ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, horizontal/vertical scan counters,
// registered sync pulses aligned with the pixel coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_DISP   = VGA_H_DISP,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_DISP   = VGA_V_DISP,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y
);

  localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [DIV_W-1:0] w_div_cnt;
  logic             w_div_wrap;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt, w_h_next, w_v_next;
  logic             w_h_wrap, w_v_wrap, w_v_en;
  logic             r_hsync, r_vsync;

  mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk(clk), .reset(reset), .en(1'b1), .q(w_div_cnt), .wrap(w_div_wrap)
  );

  mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk(clk), .reset(reset), .en(w_div_wrap), .q(w_h_cnt), .wrap(w_h_wrap)
  );

  assign w_v_en = w_div_wrap & w_h_wrap;

  mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk(clk), .reset(reset), .en(w_v_en), .q(w_v_cnt), .wrap(w_v_wrap)
  );

  // Next-state view of the counters so the sync registers land on the same edge.
  assign w_h_next = w_h_wrap ? '0 : (w_div_wrap ? w_h_cnt + 1'b1 : w_h_cnt);
  assign w_v_next = w_v_wrap ? '0 : (w_v_en ? w_v_cnt + 1'b1 : w_v_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= sync_level(1'b0, SYNC_POL);
      r_vsync <= sync_level(1'b0, SYNC_POL);
    end else begin
      r_hsync <= sync_level(in_window(w_h_next, HS_START, HS_END), SYNC_POL);
      r_vsync <= sync_level(in_window(w_v_next, VS_START, VS_END), SYNC_POL);
    end
  end

  assign p_tick   = (w_div_cnt == DIV_W'(CLK_DIV - 1));
  assign video_on = (w_h_cnt < CNT_W'(H_DISP)) && (w_v_cnt < CNT_W'(V_DISP));
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign pixel_x  = w_h_cnt;
  assign pixel_y  = w_v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks vga_sync_gen (full 640x480 timing plus a shrunken-timing copy that
// reaches vertical sync and frame wrap quickly) against an arithmetic model.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync, vsync, video_on, p_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       s_hsync, s_vsync, s_video_on, s_p_tick;
  logic [9:0] s_pixel_x, s_pixel_y;

  int n_clk = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Clock edges since the last edge that sampled reset high.
  always @(posedge clk) begin
    if (reset) n_clk <= 0;
    else       n_clk <= n_clk + 1;
  end

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .H_DISP(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .p_tick(s_p_tick), .pixel_x(s_pixel_x), .pixel_y(s_pixel_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (clk %0d after reset)", tag, obs, exp, n_clk);
    end
  endtask

  // Expected outputs after n edges: n/4 pixel ticks have elapsed since reset.
  task automatic check_cfg(input string name, input int hd, hf, hs, hb, vd, vf, vs, vb,
                           input logic o_pt, o_hs, o_vs, o_von, input logic [9:0] o_x, o_y);
    int ticks, htot, vtot, x, y;
    htot  = hd + hf + hs + hb;
    vtot  = vd + vf + vs + vb;
    ticks = n_clk / 4;
    x     = ticks % htot;
    y     = (ticks / htot) % vtot;
    chk({name, ".p_tick"},   32'(o_pt),  32'((n_clk % 4) == 3));
    chk({name, ".pixel_x"},  32'(o_x),   32'(x));
    chk({name, ".pixel_y"},  32'(o_y),   32'(y));
    chk({name, ".video_on"}, 32'(o_von), 32'((x < hd) && (y < vd)));
    chk({name, ".hsync"},    32'(o_hs),  32'(!((x >= hd + hf) && (x < hd + hf + hs))));
    chk({name, ".vsync"},    32'(o_vs),  32'(!((y >= vd + vf) && (y < vd + vf + vs))));
  endtask

  task automatic check_all();
    check_cfg("full", 640, 16, 96, 48, 480, 10, 2, 33,
              p_tick, hsync, vsync, video_on, pixel_x, pixel_y);
    check_cfg("small", 16, 2, 3, 3, 12, 2, 2, 3,
              s_p_tick, s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    $display("step: reset released");
    run(12);
    $display("step: first ticks checked");
    run(4 * 800 * 2 + 16);
    $display("step: two full lines checked (wrap 799->0, line advance)");
    repeat (4) begin
      int len;
      len = int'($urandom_range(100, 2500));
      run(len);
      $display("step: random run of %0d clks, pixel_x=%0d pixel_y=%0d", len, pixel_x, pixel_y);
      @(negedge clk);
      reset = 1'b1;
      run(10);
      $display("step: reset held 10 clks mid-line");
      reset = 1'b0;
    end
    run(2 * 1824 + 50);
    $display("step: small-timing frames wrapped");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
